// File: rtl/mpu_capture_pkg.sv
// ============================================================================
// mpu_capture_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the MPU6050 capture block:
//   - fsm_state_t   : state of the dominant-axis compare FSM
//   - TIC_DIV_DEF   : default MCLK cycles per TIC period
//   - DEADBAND_DEF  : default magnitude dead-band
//   - adr_hi/adr_lo : byte address of the high/low byte of channel k
// ============================================================================
package mpu_capture_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN     = 2'd1,
        DECIDE   = 2'd2,
        WAIT_TIC = 2'd3
    } fsm_state_t;

    localparam int TIC_DIV_DEF  = 161;
    localparam int DEADBAND_DEF = 512;

    // Samples arrive big-endian: the high byte of channel k sits at the even
    // address, the low byte right after it.
    function automatic int adr_hi(input int k);
        return 2 * k;
    endfunction

    function automatic int adr_lo(input int k);
        return 2 * k + 1;
    endfunction

endpackage

// File: rtl/mpu_tic_gen.sv
// ============================================================================
// mpu_tic_gen
// ----------------------------------------------------------------------------
// Free-running divider producing a one-cycle TIC strobe every TIC_DIV cycles.
// The counter runs 0..TIC_DIV-1 and TIC is high while it sits at TIC_DIV-1,
// so the first TIC appears TIC_DIV-1 cycles after SRST is released.
//
// Ports:
//   MCLK  in   system clock
//   SRST  in   synchronous active-high reset
//   TIC   out  one-cycle strobe, once per TIC_DIV cycles
// ============================================================================
module mpu_tic_gen
    import mpu_capture_pkg::*;
#(
    parameter int TIC_DIV = TIC_DIV_DEF
) (
    input  logic MCLK,
    input  logic SRST,
    output logic TIC
);

    localparam int CW = (TIC_DIV > 2) ? $clog2(TIC_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIC_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge MCLK) begin
        if (SRST) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    // Decoded straight from the counter register, so it is glitch-free and
    // lines up with the cycle in which the count holds its last value.
    assign TIC = (count_reg == LAST);

endmodule

// File: rtl/mpu_axis_capture.sv
// ============================================================================
// mpu_axis_capture
// ----------------------------------------------------------------------------
// Tick generation, per-channel byte capture, atomic frame publish and a
// sequential dominant-axis search with dead-band for the MPU6050 demo.
//
// Ports:
//   MCLK        in   system clock (only clock)
//   SRST        in   synchronous active-high reset
//   TIC         out  one-cycle strobe every TIC_DIV cycles
//   LOAD        in   byte strobe, honoured only in TIC cycles
//   ADR         in   byte index (2k = high byte of ch k, 2k+1 = low byte)
//   DATA        in   byte value
//   COMPLETED   in   frame-end strobe, honoured only in TIC cycles
//   RESCAN      out  next-frame request, high in one TIC cycle after DECIDE
//   SAMPLES     out  published samples, channel k at [k*DW +: DW]
//   FRAME_VALID out  one-cycle pulse when SAMPLES updates
//   FRAME_CNT   out  accepted frame count, wraps at 256
//   LED         out  one-hot dominant channel, zero inside the dead-band
//   SIGN        out  sign of the dominant sample, zero when LED is zero
//   OVERRUN     out  sticky: COMPLETED seen while the FSM was busy
// ============================================================================
module mpu_axis_capture
    import mpu_capture_pkg::*;
#(
    parameter int TIC_DIV  = TIC_DIV_DEF,
    parameter int NCH      = 3,
    parameter int DW       = 16,
    parameter int ADR_W    = 4,
    parameter int DEADBAND = DEADBAND_DEF
) (
    input  logic              MCLK,
    input  logic              SRST,
    output logic              TIC,
    input  logic              LOAD,
    input  logic [ADR_W-1:0]  ADR,
    input  logic [7:0]        DATA,
    input  logic              COMPLETED,
    output logic              RESCAN,
    output logic [NCH*DW-1:0] SAMPLES,
    output logic              FRAME_VALID,
    output logic [7:0]        FRAME_CNT,
    output logic [NCH-1:0]    LED,
    output logic              SIGN,
    output logic              OVERRUN
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] LAST_CH  = IW'(NCH - 1);
    localparam logic [DW-1:0] DB       = DW'(DEADBAND);
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};

    logic tic;
    logic byte_wr;

    // Staging bytes with the current TIC write folded in, so a byte written
    // in the same TIC as COMPLETED lands in the published frame.
    logic [NCH*DW-1:0] staging_view;

    fsm_state_t        state_reg;
    logic [IW-1:0]     scan_idx_reg;
    logic [IW-1:0]     win_idx_reg;
    logic [DW-1:0]     max_mag_reg;
    logic [NCH*DW-1:0] samples_reg;
    logic              frame_valid_reg;
    logic [7:0]        frame_cnt_reg;
    logic [NCH-1:0]    led_reg;
    logic              sign_reg;
    logic              overrun_reg;

    logic [DW-1:0]     cur_sample;
    logic [DW-1:0]     cur_mag;
    logic [DW-1:0]     win_sample;

    mpu_tic_gen #(
        .TIC_DIV (TIC_DIV)
    ) u_tic_gen (
        .MCLK (MCLK),
        .SRST (SRST),
        .TIC  (tic)
    );

    assign byte_wr = tic && LOAD;

    // ------------------------------------------------------------------
    // Staging registers: one high byte per channel, plus a low byte when
    // samples are 16 bits wide. Addresses outside 0..2*NCH-1 match no
    // byte and are dropped; with DW=8 odd addresses have no target.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [7:0] hi_reg;
            logic [7:0] hi_view;
            logic       hi_wr;

            assign hi_wr   = byte_wr && (ADR == ADR_W'(adr_hi(gi)));
            assign hi_view = hi_wr ? DATA : hi_reg;

            always_ff @(posedge MCLK) begin
                if (SRST) begin
                    hi_reg <= '0;
                end else if (hi_wr) begin
                    hi_reg <= DATA;
                end
            end

            if (DW == 16) begin : g_lo
                logic [7:0] lo_reg;
                logic [7:0] lo_view;
                logic       lo_wr;

                assign lo_wr   = byte_wr && (ADR == ADR_W'(adr_lo(gi)));
                assign lo_view = lo_wr ? DATA : lo_reg;

                always_ff @(posedge MCLK) begin
                    if (SRST) begin
                        lo_reg <= '0;
                    end else if (lo_wr) begin
                        lo_reg <= DATA;
                    end
                end

                assign staging_view[gi*DW +: DW] = {hi_view, lo_view};
            end else begin : g_byte
                assign staging_view[gi*DW +: DW] = hi_view;
            end
        end
    endgenerate

    // Magnitude of the channel under scan. The most negative value has no
    // positive counterpart in DW bits, so it saturates to the largest
    // positive value instead of wrapping back to itself.
    always_comb begin
        cur_sample = samples_reg[scan_idx_reg*DW +: DW];
        win_sample = samples_reg[win_idx_reg*DW +: DW];
        if (!cur_sample[DW-1]) begin
            cur_mag = cur_sample;
        end else if (cur_sample == MOST_NEG) begin
            cur_mag = MAX_POS;
        end else begin
            cur_mag = -cur_sample;
        end
    end

    // ------------------------------------------------------------------
    // Publish + compare FSM
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (SRST) begin
            state_reg       <= IDLE;
            scan_idx_reg    <= '0;
            win_idx_reg     <= '0;
            max_mag_reg     <= '0;
            samples_reg     <= '0;
            frame_valid_reg <= 1'b0;
            frame_cnt_reg   <= '0;
            led_reg         <= '0;
            sign_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            frame_valid_reg <= 1'b0;

            // A frame is only accepted while idle; otherwise the previous
            // result is still being computed and the new one is dropped.
            if (tic && COMPLETED) begin
                if (state_reg == IDLE) begin
                    samples_reg     <= staging_view;
                    frame_valid_reg <= 1'b1;
                    frame_cnt_reg   <= frame_cnt_reg + 8'd1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (tic && COMPLETED) begin
                        state_reg    <= SCAN;
                        scan_idx_reg <= '0;
                        win_idx_reg  <= '0;
                        max_mag_reg  <= '0;
                    end
                end
                SCAN: begin
                    // Strictly greater: on a tie the lower index keeps it.
                    if (cur_mag > max_mag_reg) begin
                        max_mag_reg <= cur_mag;
                        win_idx_reg <= scan_idx_reg;
                    end
                    if (scan_idx_reg == LAST_CH) begin
                        state_reg <= DECIDE;
                    end else begin
                        scan_idx_reg <= scan_idx_reg + IW'(1);
                    end
                end
                DECIDE: begin
                    if (max_mag_reg > DB) begin
                        led_reg  <= NCH'(1) << win_idx_reg;
                        sign_reg <= win_sample[DW-1];
                    end else begin
                        led_reg  <= '0;
                        sign_reg <= 1'b0;
                    end
                    state_reg <= WAIT_TIC;
                end
                WAIT_TIC: begin
                    if (tic) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // RESCAN has to coincide with a TIC cycle, so it is decoded from the
    // registered state and the registered-counter TIC rather than delayed.
    assign RESCAN      = (state_reg == WAIT_TIC) && tic;
    assign TIC         = tic;
    assign SAMPLES     = samples_reg;
    assign FRAME_VALID = frame_valid_reg;
    assign FRAME_CNT   = frame_cnt_reg;
    assign LED         = led_reg;
    assign SIGN        = sign_reg;
    assign OVERRUN     = overrun_reg;

endmodule

// File: tb/tb_mpu_axis_capture.sv
// ============================================================================
// tb_mpu_axis_capture
// ----------------------------------------------------------------------------
// Scoreboard bench for mpu_axis_capture with default parameters. A reference
// model observes the driven inputs on every rising edge, keeps its own byte
// staging and busy flag, and pushes the expected frame result into a queue on
// every accepted COMPLETED. A monitor pops that queue on FRAME_VALID and
// checks SAMPLES, FRAME_CNT, OVERRUN and, later, LED and SIGN. A separate
// checker compares TIC and RESCAN every cycle against the model's tick phase.
// ============================================================================
module tb_mpu_axis_capture;

    localparam int TIC_DIV  = 161;
    localparam int NCH      = 3;
    localparam int DW       = 16;
    localparam int ADR_W    = 4;
    localparam int DEADBAND = 512;

    logic              clk = 1'b0;
    logic              srst = 1'b1;
    logic              load = 1'b0;
    logic [ADR_W-1:0]  adr = '0;
    logic [7:0]        data = '0;
    logic              completed = 1'b0;
    logic              tic;
    logic              rescan;
    logic [NCH*DW-1:0] samples;
    logic              frame_valid;
    logic [7:0]        frame_cnt;
    logic [NCH-1:0]    led;
    logic              sign;
    logic              overrun;

    always #5 clk = ~clk;

    mpu_axis_capture #(
        .TIC_DIV  (TIC_DIV),
        .NCH      (NCH),
        .DW       (DW),
        .ADR_W    (ADR_W),
        .DEADBAND (DEADBAND)
    ) dut (
        .MCLK        (clk),
        .SRST        (srst),
        .TIC         (tic),
        .LOAD        (load),
        .ADR         (adr),
        .DATA        (data),
        .COMPLETED   (completed),
        .RESCAN      (rescan),
        .SAMPLES     (samples),
        .FRAME_VALID (frame_valid),
        .FRAME_CNT   (frame_cnt),
        .LED         (led),
        .SIGN        (sign),
        .OVERRUN     (overrun)
    );

    typedef struct {
        logic [NCH*DW-1:0] samples;
        logic [7:0]        cnt;
        logic [NCH-1:0]    led;
        logic              sign;
        logic              ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] stg [2*NCH];
    int         tcnt  = 0;     // cycles since the last TIC (TIC when TIC_DIV-1)
    bit         pend  = 1'b0;  // a frame was accepted and its TIC release is due
    bit         ov_m  = 1'b0;
    logic [7:0] cnt_m = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected outcome of publishing the current staging bytes.
    task automatic model_accept();
        exp_t e;
        int best, win, m, sv;
        logic [DW-1:0] s;
        e.samples = '0;
        best = -1;
        win  = 0;
        for (int k = 0; k < NCH; k++) begin
            s = {stg[2*k], stg[2*k+1]};
            e.samples[k*DW +: DW] = s;
            sv = int'($signed(s));
            m  = (sv < 0) ? -sv : sv;
            if (m > 2**(DW-1) - 1) m = 2**(DW-1) - 1;
            if (m > best) begin
                best = m;
                win  = k;
            end
        end
        cnt_m  = cnt_m + 8'd1;
        e.cnt  = cnt_m;
        e.ov   = ov_m;
        if (best > DEADBAND) begin
            e.led  = NCH'(1) << win;
            e.sign = e.samples[win*DW + DW - 1];
        end else begin
            e.led  = '0;
            e.sign = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Model: sample the driven inputs on each rising edge.
    initial begin
        foreach (stg[i]) stg[i] = 8'h00;
        forever begin
            @(posedge clk);
            if (srst) begin
                tcnt  = 0;
                pend  = 1'b0;
                ov_m  = 1'b0;
                cnt_m = '0;
                foreach (stg[i]) stg[i] = 8'h00;
                exp_q.delete();
            end else if (tcnt == TIC_DIV - 1) begin
                if (load && (adr < 2*NCH)) stg[adr] = data;
                if (completed && !pend) begin
                    model_accept();
                    pend = 1'b1;
                end else begin
                    if (completed) ov_m = 1'b1;
                    pend = 1'b0;
                end
                tcnt = 0;
            end else begin
                tcnt++;
            end
        end
    end

    // Per-cycle tick and rescan checker.
    initial begin
        forever begin
            @(negedge clk);
            check("tic", tic, tcnt == TIC_DIV - 1);
            check("rescan", rescan, (tcnt == TIC_DIV - 1) && pend);
        end
    end

    // Monitor: compare each published frame against the scoreboard.
    initial begin
        bit aborted;
        forever begin
            @(negedge clk);
            if (frame_valid !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("frame_valid_unexpected", frame_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("samples", samples, mon_e.samples);
                    check("frame_cnt", frame_cnt, mon_e.cnt);
                    check("overrun", overrun, mon_e.ov);
                    aborted = 1'b0;
                    repeat (NCH + 2) begin
                        @(negedge clk);
                        if (srst) aborted = 1'b1;
                    end
                    if (!aborted) begin
                        check("led", led, mon_e.led);
                        check("sign", sign, mon_e.sign);
                        $display("frame cnt=%0d samples=%h led=%b sign=%b", mon_e.cnt,
                                 mon_e.samples, mon_e.led, mon_e.sign);
                    end
                end
            end
        end
    end

    // Drive one set of inputs during the next TIC cycle, then clear them.
    task automatic tic_op(input bit l, input logic [ADR_W-1:0] a, input logic [7:0] d, input bit c);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tcnt != TIC_DIV - 1 && n <= TIC_DIV + 1);
        load      = l;
        adr       = a;
        data      = d;
        completed = c;
        @(negedge clk);
        load      = 1'b0;
        adr       = '0;
        data      = '0;
        completed = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_samples"}, samples, 0);
        check({tag, "_frame_valid"}, frame_valid, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_led"}, led, 0);
        check({tag, "_sign"}, sign, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_rescan"}, rescan, 0);
        check({tag, "_tic"}, tic, 0);
    endtask

    initial begin
        int guard;
        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        srst = 1'b0;

        // Idle TICs before any frame: outputs remain zero
        tic_op(1'b0, 4'd0, 8'h00, 1'b0);
        check("idle_samples", samples, 0);
        check("idle_led", led, 0);
        check("idle_frame_cnt", frame_cnt, 0);

        // X=0x0100, Y=0xFC00, Z=0x0050 -> Y dominant, negative
        tic_op(1'b1, 4'd0, 8'h01, 1'b0);
        tic_op(1'b1, 4'd2, 8'hFC, 1'b0);
        tic_op(1'b1, 4'd5, 8'h50, 1'b0);
        tic_op(1'b0, 4'd0, 8'h00, 1'b1);
        tic_op(1'b0, 4'd0, 8'h00, 1'b0);

        // X=0x0200, Y=0xFE01, Z=0 -> max magnitude equals the dead-band
        tic_op(1'b1, 4'd0, 8'h02, 1'b0);
        tic_op(1'b1, 4'd2, 8'hFE, 1'b0);
        tic_op(1'b1, 4'd3, 8'h01, 1'b0);
        tic_op(1'b1, 4'd5, 8'h00, 1'b0);
        tic_op(1'b0, 4'd0, 8'h00, 1'b1);
        tic_op(1'b0, 4'd0, 8'h00, 1'b0);
        // X low byte 0x01 written in the same TIC as COMPLETED -> X=0x0201
        tic_op(1'b1, 4'd1, 8'h01, 1'b1);
        tic_op(1'b0, 4'd0, 8'h00, 1'b0);

        // X=0x8000 (saturates) ties Y=0x7FFF; stray writes must be ignored
        tic_op(1'b1, 4'd0, 8'h80, 1'b0);
        tic_op(1'b1, 4'd1, 8'h00, 1'b0);
        tic_op(1'b1, 4'd2, 8'h7F, 1'b0);
        tic_op(1'b1, 4'd3, 8'hFF, 1'b0);
        @(negedge clk);
        load = 1'b1; adr = 4'd0; data = 8'h55;   // not a TIC cycle
        @(negedge clk);
        load = 1'b0; adr = '0; data = '0;
        tic_op(1'b1, 4'd6, 8'hAA, 1'b0);
        tic_op(1'b1, 4'd15, 8'h77, 1'b0);
        tic_op(1'b0, 4'd0, 8'h00, 1'b1);

        // COMPLETED on the next TIC while waiting -> overrun, count unchanged
        tic_op(1'b0, 4'd0, 8'h00, 1'b1);
        check("overrun_set", overrun, 1'b1);
        check("frame_cnt_hold", frame_cnt, cnt_m);

        // Random frames until the frame counter wraps to zero
        guard = 0;
        while (cnt_m != 8'd0 && guard < 300) begin
            tic_op(1'($urandom_range(0, 1)), ADR_W'($urandom_range(0, 7)), 8'($urandom), 1'b1);
            tic_op(1'($urandom_range(0, 1)), ADR_W'($urandom_range(0, 7)), 8'($urandom), 1'b0);
            guard++;
        end
        check("frame_cnt_wrap", frame_cnt, 8'd0);

        // Reset during SCAN
        tic_op(1'b1, 4'd0, 8'h12, 1'b0);
        tic_op(1'b1, 4'd3, 8'h34, 1'b1);
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        check_all_zero("scan_reset");
        @(negedge clk);
        srst = 1'b0;

        // Fresh frame after reset: Z=0xF000 dominant, negative
        tic_op(1'b1, 4'd4, 8'hF0, 1'b0);
        tic_op(1'b0, 4'd0, 8'h00, 1'b1);
        tic_op(1'b0, 4'd0, 8'h00, 1'b0);

        repeat (10) @(negedge clk);
        check("frames_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
